// File: rtl/button_conditioner.sv
// button_conditioner
//
// Front-end for the coffee controller's push-buttons. There are two identical,
// independent channels: channel 0 is NEXT and channel 1 is SELECT. Each channel
// works in three steps:
//   1. A two-flop synchroniser (s1 -> s2) brings the raw pin into the clk domain.
//   2. A debouncer built around a consecutive-sample counter accepts a level
//      change only after DEBOUNCE_CYCLES stable mismatching samples of s2.
//   3. A registered single-cycle press pulse is raised on each debounced 0 -> 1.
//
// Optional feature, selected by the macro NEXT_AUTOREPEAT_EN:
//   Holding NEXT produces repeat pulses. The first repeat comes REPEAT_DELAY
//   cycles after the press pulse, and later ones follow every REPEAT_PERIOD
//   cycles. SELECT never repeats. When the macro is not defined there is exactly
//   one pulse per press, and the REPEAT_* parameters are ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable s2 samples needed to accept a change (>= 1)
//   REPEAT_DELAY     press pulse to first repeat pulse, in cycles (>= 1)
//   REPEAT_PERIOD    spacing of later repeat pulses, in cycles (>= 1)
//
// Ports:
//   clk            system clock (the only clock)
//   reset          synchronous, active-high reset
//   next_raw       raw NEXT pin (asynchronous, bouncing, active-high)
//   select_raw     raw SELECT pin (asynchronous, bouncing, active-high)
//   next_button    one-cycle NEXT press pulse
//   select_button  one-cycle SELECT press pulse
//   next_level     debounced NEXT level
//   select_level   debounced SELECT level

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic next_raw,
  input  logic select_raw,
  output logic next_button,
  output logic select_button,
  output logic next_level,
  output logic select_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // The debounced level is encoded in the state itself: PRESSED and
  // CONFIRM_RELEASE mean level 1. The CONFIRM_* states are the cycles in which
  // the counter is running.
  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_t;

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] pulse_d;
  logic [1:0] pulse;

`ifdef NEXT_AUTOREPEAT_EN
  logic next_lvl_nx;
`endif

  assign raw = {select_raw, next_raw};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    state_t        state;
    state_t        state_next;
    logic          done;
    logic          press_ch;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // 'done' means this is the DEBOUNCE_CYCLES-th consecutive mismatching
    // sample. The counter clears whenever s2 agrees with the level, so it can
    // never run past CNT_LAST.
    assign done = (cnt == CNT_LAST);

    always_comb begin
      state_next = state;
      cnt_next   = '0;
      press_ch   = 1'b0;
      unique case (state)
        IDLE: begin
          if (s2) begin
            if (done) begin
              state_next = PRESSED;
              press_ch   = 1'b1;
            end else begin
              state_next = CONFIRM_PRESS;
              cnt_next   = cnt + CW'(1);
            end
          end
        end
        CONFIRM_PRESS: begin
          if (!s2) begin
            state_next = IDLE;
          end else if (done) begin
            state_next = PRESSED;
            press_ch   = 1'b1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s2) begin
            if (done) begin
              state_next = IDLE;
            end else begin
              state_next = CONFIRM_RELEASE;
              cnt_next   = cnt + CW'(1);
            end
          end
        end
        CONFIRM_RELEASE: begin
          if (s2) begin
            state_next = PRESSED;
          end else if (done) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    assign level[i] = (state == PRESSED) || (state == CONFIRM_RELEASE);
    assign press[i] = press_ch;

`ifdef NEXT_AUTOREPEAT_EN
    if (i == 0) begin : g_nx
      // This is the level that will hold after the coming edge. It lets the
      // repeat logic suppress a pulse on the same edge on which the level falls.
      assign next_lvl_nx = (state_next == PRESSED) || (state_next == CONFIRM_RELEASE);
    end
`endif
  end

`ifdef NEXT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rep_fire;

  // This is a down-counter. It is loaded on the press edge and fires when it
  // reaches zero, then reloads with the period. When the press pulse is at edge
  // P, the first fire is at edge P+REPEAT_DELAY.
  assign rep_fire = level[0] & next_lvl_nx & (rcnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
    end else if (!next_lvl_nx) begin
      rcnt <= '0;
    end else if (press[0]) begin
      rcnt <= RW'(REPEAT_DELAY - 1);
    end else if (rcnt == '0) begin
      rcnt <= RW'(REPEAT_PERIOD - 1);
    end else begin
      rcnt <= rcnt - RW'(1);
    end
  end

  assign pulse_d = {press[1], press[0] | rep_fire};
`else
  assign pulse_d = press;
`endif

  // The press pulses are registered. They are set on the same edge on which the
  // level rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse <= 2'b00;
    end else begin
      pulse <= pulse_d;
    end
  end

  assign next_button   = pulse[0];
  assign select_button = pulse[1];
  assign next_level    = level[0];
  assign select_level  = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner. The debounce and repeat parameters are set
// to small values here.
//
// The stimulus process pushes the cycle number of every expected press or
// repeat pulse into a per-channel queue. A monitor process samples the outputs
// on each falling edge. When a pulse appears, the monitor pops the queue entry
// and compares the cycle numbers. Any expected pulse that is overdue is
// reported as missed. Levels are checked directly by the stimulus process.
// Cycle numbering: 'cyc' counts rising edges. Inputs are changed just after a
// falling edge while cyc == k. A clean change made at that point first shows on
// the outputs in cycle k + DEB + 2.

module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;
  localparam int LAT = DEB + 2;

  logic clk        = 1'b0;
  logic reset      = 1'b1;
  logic next_raw   = 1'b0;
  logic select_raw = 1'b0;
  logic next_button, select_button, next_level, select_level;

  int cyc    = 0;
  int total  = 0;
  int passed = 0;
  int q[2][$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .next_raw     (next_raw),
    .select_raw   (select_raw),
    .next_button  (next_button),
    .select_button(select_button),
    .next_level   (next_level),
    .select_level (select_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Queue the press pulse for channel ch at cycle p. On NEXT with auto-repeat
  // enabled, also queue the repeat pulses that land before cycle f, the cycle
  // in which the level falls.
  task automatic expect_press(input int ch, input int p, input int f);
    q[ch].push_back(p);
`ifdef NEXT_AUTOREPEAT_EN
    if (ch == 0)
      for (int r = p + RD; r < f; r += RP) q[ch].push_back(r);
`endif
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [1:0] btn;
    btn = {select_button, next_button};
    for (int ch = 0; ch < 2; ch++) begin
      while (q[ch].size() > 0 && q[ch][0] < cyc) begin
        total++;
        $display("FAIL pulse_ch%0d: no pulse seen, required at cycle %0d", ch, q[ch][0]);
        void'(q[ch].pop_front());
      end
      if (btn[ch] === 1'b1) begin
        total++;
        if (q[ch].size() > 0 && q[ch][0] == cyc) begin
          passed++;
          void'(q[ch].pop_front());
        end else begin
          $display("FAIL pulse_ch%0d: pulse at cycle %0d, none required", ch, cyc);
        end
      end
    end
  end

  initial begin
    int k;
    int r;

    // 1. Reset with both buttons held, then release reset.
    next_raw   = 1'b1;
    select_raw = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", int'({next_button, select_button, next_level, select_level}), 0);
    end
    k = cyc;
    reset = 1'b0;
    expect_press(0, k + LAT, k + 2 * LAT);
    expect_press(1, k + LAT, 0);
    repeat (LAT) @(negedge clk);
    check("levels_after_reset_press", int'({next_level, select_level}), 3);
    next_raw   = 1'b0;
    select_raw = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("levels_before_release", int'({next_level, select_level}), 3);
    @(negedge clk);
    check("levels_after_release", int'({next_level, select_level}), 0);

    // 2. Bounce on NEXT for 12 cycles, then a clean hold.
    repeat (3) @(negedge clk);
    k = cyc;
    for (int i = 0; i < 6; i++) begin
      next_raw = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    check("bounce_level", int'(next_level), 0);
    next_raw = 1'b1;
    expect_press(0, k + 12 + LAT, k + 12 + 2 * LAT);
    repeat (LAT) @(negedge clk);
    check("bounce_level_pressed", int'(next_level), 1);
    next_raw = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check("release_level_hold", int'(next_level), 1);
    @(negedge clk);
    check("release_level_fall", int'(next_level), 0);

    // 3. Glitch of 3 cycles on SELECT.
    repeat (3) @(negedge clk);
    select_raw = 1'b1;
    repeat (3) @(negedge clk);
    select_raw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("glitch_level", int'(select_level), 0);
      check("glitch_pulse", int'(select_button), 0);
    end

    // 4. Reset two cycles into a NEXT press debounce, raw still held.
    repeat (3) @(negedge clk);
    k = cyc;
    next_raw = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_mid_debounce_level", int'(next_level), 0);
    check("reset_mid_debounce_pulse", int'(next_button), 0);
    r = cyc;
    reset = 1'b0;
    expect_press(0, r + LAT, r + 2 * LAT);
    repeat (LAT) @(negedge clk);
    check("repress_after_reset_level", int'(next_level), 1);
    next_raw = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("repress_release_level", int'(next_level), 0);

    // 5. Long hold on NEXT. The level falls 35 cycles after the press pulse,
    //    so with auto-repeat the pulses are at P, P+10, P+15, ... P+30.
    repeat (3) @(negedge clk);
    k = cyc;
    next_raw = 1'b1;
    expect_press(0, k + LAT, k + 35 + LAT);
    repeat (35) @(negedge clk);
    check("hold_level", int'(next_level), 1);
    next_raw = 1'b0;
    repeat (25) @(negedge clk);
    check("hold_release_level", int'(next_level), 0);

    repeat (3) @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      while (q[ch].size() > 0) begin
        total++;
        $display("FAIL pulse_ch%0d: no pulse seen, required at cycle %0d", ch, q[ch][0]);
        void'(q[ch].pop_front());
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
